// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the MEM-stage store path: op encodings, trap causes, FSM states.
package mem_store_unit_pkg;

    localparam int unsigned OP_WIDTH = 3;

    // Encodings match the RISC-V store funct3 field.
    localparam logic [OP_WIDTH-1:0] MEM_STORE_B = 3'd0;
    localparam logic [OP_WIDTH-1:0] MEM_STORE_H = 3'd1;
    localparam logic [OP_WIDTH-1:0] MEM_STORE_W = 3'd2;

    localparam logic [3:0] EXC_CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] EXC_CAUSE_STORE_ACCESS     = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } store_state_e;

endpackage

// File: rtl/mem_store_unit_if.sv
// Data-memory write bus: the store unit is master, the memory is slave.
interface mem_store_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        mem_err;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_err
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_err
    );

endinterface

// File: rtl/mem_store_unit_store_align.sv
// Combinational lane alignment: replicates store data into word lanes and builds byte strobes.
module store_align
    import mem_store_unit_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op,
    input  logic [1:0]          addr_lo,
    input  logic [31:0]         din,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                misaligned
);

    always_comb begin
        wdata      = '0;
        wstrb      = '0;
        misaligned = 1'b0;
        unique case (op)
            MEM_STORE_B: begin
                wdata = {4{din[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            MEM_STORE_H: begin
                wdata      = {2{din[15:0]}};
                wstrb      = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
            end
            MEM_STORE_W: begin
                wdata      = din;
                wstrb      = '1;
                misaligned = (addr_lo != 2'b00);
            end
            // Undefined ops trap the same way as a misaligned store.
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store unit: aligns a store, runs one req/ack write on the data bus, reports done or a trap.
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 15,
    parameter logic [3:0]  CAUSE_MIS = EXC_CAUSE_STORE_MISALIGNED,
    parameter logic [3:0]  CAUSE_ACC = EXC_CAUSE_STORE_ACCESS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [31:0]         addr,
    input  logic [31:0]         din,
    input  logic                flush,
    mem_store_unit_if.master    bus,
    output logic                stall,
    output logic                done,
    output logic                exc_valid,
    output logic [3:0]          exc_cause,
    output logic [31:0]         exc_tval
);

    localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    store_state_e state, state_n;
    logic             req_q, req_n;
    logic [31:0]      baddr_q, baddr_n;
    logic [31:0]      wdata_q, wdata_n;
    logic [3:0]       wstrb_q, wstrb_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             done_q, done_n;
    logic             exc_q, exc_n;
    logic [3:0]       cause_q, cause_n;
    logic [31:0]      tval_q, tval_n;

    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic        al_mis;
    logic        accept;

    store_align u_align (
        .op         (op),
        .addr_lo    (addr[1:0]),
        .din        (din),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .misaligned (al_mis)
    );

    assign in_ready = (state == ST_IDLE);
    assign stall    = (state == ST_WAIT);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_n = state;
        req_n   = req_q;
        baddr_n = baddr_q;
        wdata_n = wdata_q;
        wstrb_n = wstrb_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        exc_n   = 1'b0;
        cause_n = cause_q;
        tval_n  = tval_q;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (al_mis) begin
                        exc_n   = 1'b1;
                        cause_n = CAUSE_MIS;
                        tval_n  = addr;
                    end else begin
                        state_n = ST_WAIT;
                        req_n   = 1'b1;
                        baddr_n = addr;
                        wdata_n = al_wdata;
                        wstrb_n = al_wstrb;
                        cnt_n   = '0;
                    end
                end
            end
            ST_WAIT: begin
                // Ack is checked before the timeout so a last-cycle ack still completes.
                if (bus.mem_ack) begin
                    state_n = ST_IDLE;
                    req_n   = 1'b0;
                    if (bus.mem_err) begin
                        exc_n   = 1'b1;
                        cause_n = CAUSE_ACC;
                        tval_n  = baddr_q;
                    end else begin
                        done_n = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                    state_n = ST_IDLE;
                    req_n   = 1'b0;
                    exc_n   = 1'b1;
                    cause_n = CAUSE_ACC;
                    tval_n  = baddr_q;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            baddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            baddr_q <= baddr_n;
            wdata_q <= wdata_n;
            wstrb_q <= wstrb_n;
            cnt_q   <= cnt_n;
            done_q  <= done_n;
            exc_q   <= exc_n;
            cause_q <= cause_n;
            tval_q  <= tval_n;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = {baddr_q[31:2], 2'b00};
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign done          = done_q;
    assign exc_valid     = exc_q;
    assign exc_cause     = cause_q;
    assign exc_tval      = tval_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit and its store_align lane table.
module tb_mem_store_unit;
    import mem_store_unit_pkg::*;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] op;
    logic [31:0]         addr;
    logic [31:0]         din;
    logic                flush;
    logic                stall;
    logic                done;
    logic                exc_valid;
    logic [3:0]          exc_cause;
    logic [31:0]         exc_tval;

    logic [OP_WIDTH-1:0] a_op;
    logic [1:0]          a_lo;
    logic [31:0]         a_din;
    logic [31:0]         a_wdata;
    logic [3:0]          a_wstrb;
    logic                a_mis;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mem_store_unit_if bus_if ();

    mem_store_unit #(
        .MAX_WAIT  (15),
        .CAUSE_MIS (4'd6),
        .CAUSE_ACC (4'd7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .addr      (addr),
        .din       (din),
        .flush     (flush),
        .bus       (bus_if),
        .stall     (stall),
        .done      (done),
        .exc_valid (exc_valid),
        .exc_cause (exc_cause),
        .exc_tval  (exc_tval)
    );

    store_align u_align_tb (
        .op         (a_op),
        .addr_lo    (a_lo),
        .din        (a_din),
        .wdata      (a_wdata),
        .wstrb      (a_wstrb),
        .misaligned (a_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [OP_WIDTH-1:0] o, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        op       = o;
        addr     = a;
        din      = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic ack(input logic err);
        bus_if.mem_ack = 1'b1;
        bus_if.mem_err = err;
        step();
        bus_if.mem_ack = 1'b0;
        bus_if.mem_err = 1'b0;
    endtask

    // Lane table: op, addr[1:0], din, wdata, wstrb, misaligned
    typedef struct {
        logic [2:0]  o;
        logic [1:0]  lo;
        logic [31:0] d;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        mis;
    } lane_vec_t;

    lane_vec_t lanes[8];

    initial begin
        int cycles;

        lanes[0] = '{3'd0, 2'd0, 32'h1122_3344, 32'h4444_4444, 4'b0001, 1'b0};
        lanes[1] = '{3'd0, 2'd2, 32'h1122_3344, 32'h4444_4444, 4'b0100, 1'b0};
        lanes[2] = '{3'd0, 2'd3, 32'hAABB_CCDD, 32'hDDDD_DDDD, 4'b1000, 1'b0};
        lanes[3] = '{3'd1, 2'd0, 32'h1234_5678, 32'h5678_5678, 4'b0011, 1'b0};
        lanes[4] = '{3'd1, 2'd2, 32'h1234_5678, 32'h5678_5678, 4'b1100, 1'b0};
        lanes[5] = '{3'd1, 2'd1, 32'h1234_5678, 32'h5678_5678, 4'b0110, 1'b1};
        lanes[6] = '{3'd2, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 1'b0};
        lanes[7] = '{3'd2, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 1'b1};

        rst = 1'b1; in_valid = 1'b0; op = '0; addr = '0; din = '0; flush = 1'b0;
        bus_if.mem_ack = 1'b0; bus_if.mem_err = 1'b0;
        a_op = '0; a_lo = '0; a_din = '0;

        for (int i = 0; i < 8; i++) begin
            a_op = lanes[i].o; a_lo = lanes[i].lo; a_din = lanes[i].d;
            #1;
            check($sformatf("align%0d_wdata", i), a_wdata, lanes[i].wd);
            check($sformatf("align%0d_wstrb", i), {28'd0, a_wstrb}, {28'd0, lanes[i].ws});
            check($sformatf("align%0d_mis", i), {31'd0, a_mis}, {31'd0, lanes[i].mis});
        end
        a_op = 3'd5; #1;
        check("align_undef_mis", {31'd0, a_mis}, 32'd1);

        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_req", {31'd0, bus_if.mem_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_exc", {31'd0, exc_valid}, 32'd0);
        check("rst_addr", bus_if.mem_addr, 32'd0);
        check("rst_wdata", bus_if.mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, bus_if.mem_wstrb}, 32'd0);
        check("rst_tval", exc_tval, 32'd0);
        check("rst_cause", {28'd0, exc_cause}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        // 1: SB, immediate ack
        issue(MEM_STORE_B, 32'h0000_1003, 32'hAABB_CCDD);
        check("t1_req", {31'd0, bus_if.mem_req}, 32'd1);
        check("t1_addr", bus_if.mem_addr, 32'h0000_1000);
        check("t1_wstrb", {28'd0, bus_if.mem_wstrb}, 32'h8);
        check("t1_wdata", bus_if.mem_wdata, 32'hDDDD_DDDD);
        check("t1_stall", {31'd0, stall}, 32'd1);
        check("t1_ready", {31'd0, in_ready}, 32'd0);
        ack(1'b0);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_req_drop", {31'd0, bus_if.mem_req}, 32'd0);
        check("t1_noexc", {31'd0, exc_valid}, 32'd0);
        step();
        check("t1_done_pulse", {31'd0, done}, 32'd0);

        // 2: SH, three wait cycles then ack
        issue(MEM_STORE_H, 32'h0000_2002, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_req%0d", i), {31'd0, bus_if.mem_req}, 32'd1);
            check($sformatf("t2_addr%0d", i), bus_if.mem_addr, 32'h0000_2000);
            check($sformatf("t2_wdata%0d", i), bus_if.mem_wdata, 32'h5678_5678);
            check($sformatf("t2_wstrb%0d", i), {28'd0, bus_if.mem_wstrb}, 32'hC);
            check($sformatf("t2_stall%0d", i), {31'd0, stall}, 32'd1);
            if (i < 3) step();
        end
        ack(1'b0);
        check("t2_done", {31'd0, done}, 32'd1);

        // 3: misaligned SW then SH back-to-back, then undefined op
        issue(MEM_STORE_W, 32'h0000_3001, 32'h0);
        check("t3w_req", {31'd0, bus_if.mem_req}, 32'd0);
        check("t3w_exc", {31'd0, exc_valid}, 32'd1);
        check("t3w_cause", {28'd0, exc_cause}, 32'd6);
        check("t3w_tval", exc_tval, 32'h0000_3001);
        check("t3w_ready", {31'd0, in_ready}, 32'd1);
        check("t3w_done", {31'd0, done}, 32'd0);
        issue(MEM_STORE_H, 32'h0000_3001, 32'h0);
        check("t3h_exc", {31'd0, exc_valid}, 32'd1);
        check("t3h_cause", {28'd0, exc_cause}, 32'd6);
        check("t3h_tval", exc_tval, 32'h0000_3001);
        check("t3h_req", {31'd0, bus_if.mem_req}, 32'd0);
        issue(3'd3, 32'h0000_5000, 32'h0);
        check("t3u_exc", {31'd0, exc_valid}, 32'd1);
        check("t3u_tval", exc_tval, 32'h0000_5000);
        check("t3u_req", {31'd0, bus_if.mem_req}, 32'd0);
        step();
        check("t3_exc_pulse", {31'd0, exc_valid}, 32'd0);

        // 4: timeout, bus error, and ack on the timeout cycle
        issue(MEM_STORE_W, 32'h0000_4000, 32'hDEAD_BEEF);
        cycles = 0;
        while (bus_if.mem_req === 1'b1 && cycles < 40) begin
            cycles++;
            step();
        end
        check("t4_req_cycles", cycles, 32'd16);
        check("t4_exc", {31'd0, exc_valid}, 32'd1);
        check("t4_cause", {28'd0, exc_cause}, 32'd7);
        check("t4_tval", exc_tval, 32'h0000_4000);
        check("t4_done", {31'd0, done}, 32'd0);

        issue(MEM_STORE_W, 32'h0000_4004, 32'h0);
        step();
        ack(1'b1);
        check("t4e_exc", {31'd0, exc_valid}, 32'd1);
        check("t4e_cause", {28'd0, exc_cause}, 32'd7);
        check("t4e_tval", exc_tval, 32'h0000_4004);
        check("t4e_req", {31'd0, bus_if.mem_req}, 32'd0);
        check("t4e_done", {31'd0, done}, 32'd0);

        issue(MEM_STORE_W, 32'h0000_4008, 32'h0);
        for (int i = 0; i < 15; i++) step();
        check("t4a_req_last", {31'd0, bus_if.mem_req}, 32'd1);
        ack(1'b0);
        check("t4a_done", {31'd0, done}, 32'd1);
        check("t4a_noexc", {31'd0, exc_valid}, 32'd0);

        // 5: flush in IDLE drops the request; flush in WAIT is ignored
        flush = 1'b1;
        issue(MEM_STORE_W, 32'h0000_5000, 32'h0);
        check("t5_req", {31'd0, bus_if.mem_req}, 32'd0);
        check("t5_ready", {31'd0, in_ready}, 32'd1);
        check("t5_done", {31'd0, done}, 32'd0);
        issue(MEM_STORE_W, 32'h0000_5001, 32'h0);
        check("t5_mis_noexc", {31'd0, exc_valid}, 32'd0);
        flush = 1'b0;
        issue(MEM_STORE_W, 32'h0000_6000, 32'h0);
        flush = 1'b1;
        step();
        check("t5w_req", {31'd0, bus_if.mem_req}, 32'd1);
        ack(1'b0);
        flush = 1'b0;
        check("t5w_done", {31'd0, done}, 32'd1);

        // 6: reset mid-WAIT, then a normal store
        issue(MEM_STORE_W, 32'h0000_7000, 32'h1111_2222);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_req", {31'd0, bus_if.mem_req}, 32'd0);
        check("t6_addr", bus_if.mem_addr, 32'd0);
        check("t6_wdata", bus_if.mem_wdata, 32'd0);
        check("t6_wstrb", {28'd0, bus_if.mem_wstrb}, 32'd0);
        check("t6_stall", {31'd0, stall}, 32'd0);
        issue(MEM_STORE_B, 32'h0000_7001, 32'h0000_00A5);
        check("t6n_addr", bus_if.mem_addr, 32'h0000_7000);
        check("t6n_wstrb", {28'd0, bus_if.mem_wstrb}, 32'h2);
        check("t6n_wdata", bus_if.mem_wdata, 32'hA5A5_A5A5);
        ack(1'b0);
        check("t6n_done", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
